// File: rtl/sender_arb_pkg.sv
// Shared types and constants for the Sender link arbiter.
package sender_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    GO    = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CMD_UP   = 0;
  localparam int CMD_DOWN = 1;

  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

  // Up and Down together cannot be expressed on the Sender.
  function automatic logic cmd_illegal(input logic [1:0] cmd);
    return cmd[CMD_UP] & cmd[CMD_DOWN];
  endfunction

endpackage

// File: rtl/sender_arbiter_if.sv
// Sender command/handshake link: the arbiter is master, the Sender is slave.
interface sender_arbiter_if;
  logic snd_ch1;
  logic snd_ch2;
  logic snd_up;
  logic snd_down;
  logic snd_go;
  logic snd_comp;

  modport master (
    output snd_ch1, snd_ch2, snd_up, snd_down, snd_go,
    input  snd_comp
  );

  modport slave (
    input  snd_ch1, snd_ch2, snd_up, snd_down, snd_go,
    output snd_comp
  );
endinterface

// File: rtl/sender_arbiter_rr_arb2.sv
// Two-input round-robin picker; last_grant starts at CH2 so CH1 wins the first tie.
module rr_arb2
  import sender_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req1,
  input  logic req2,
  input  logic update,
  input  logic update_ch,
  output logic any_req,
  output logic pick
);

  logic last_grant;

  always_comb begin
    any_req = req1 | req2;
    if (req1 && req2) pick = (last_grant == CH1) ? CH2 : CH1;
    else if (req2)    pick = CH2;
    else              pick = CH1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_grant <= CH2;
    else if (update) last_grant <= update_ch;
  end

endmodule

// File: rtl/sender_arbiter.sv
// Shares the Sender link between two channels: round-robin grant, go pulse, comp/timeout wait.
// Optional statistics counters are built when SENDER_ARB_STATS_EN is defined.
module sender_arbiter
  import sender_arb_pkg::*;
#(
  parameter int GO_LEN  = 1,
  parameter int TIMEOUT = 1000,
  parameter int CW      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req1,
  input  logic             req2,
  input  logic [1:0]       cmd1,
  input  logic [1:0]       cmd2,
  output logic             gnt1,
  output logic             gnt2,
  output logic             done1,
  output logic             done2,
  output logic             err,
  output logic             busy,
`ifdef SENDER_ARB_STATS_EN
  output logic [15:0]      cnt1,
  output logic [15:0]      cnt2,
  output logic [7:0]       errcnt,
`endif
  sender_arbiter_if.master snd
);

  localparam logic [3:0]    GO_LAST  = 4'(GO_LEN - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic          owner;
  logic [1:0]    cmd_q;
  logic [3:0]    go_cnt;
  logic [CW-1:0] tmo_cnt;
  logic          any_req;
  logic          pick;
  logic [1:0]    sel_cmd;
  logic          fin;
  logic          fin_err;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req1      (req1),
    .req2      (req2),
    .update    (state == DONE),
    .update_ch (owner),
    .any_req   (any_req),
    .pick      (pick)
  );

  // fin marks the last cycle of SETUP (illegal cmd) or WAIT; comp beats expiry.
  always_comb begin
    sel_cmd = (pick == CH1) ? cmd1 : cmd2;
    fin     = 1'b0;
    fin_err = 1'b0;
    case (state)
      SETUP: if (cmd_illegal(cmd_q)) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
      WAIT: begin
        if (snd.snd_comp) begin
          fin = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= CH1;
      cmd_q        <= '0;
      go_cnt       <= '0;
      tmo_cnt      <= '0;
      gnt1         <= 1'b0;
      gnt2         <= 1'b0;
      done1        <= 1'b0;
      done2        <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
      snd.snd_ch1  <= 1'b0;
      snd.snd_ch2  <= 1'b0;
      snd.snd_up   <= 1'b0;
      snd.snd_down <= 1'b0;
      snd.snd_go   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (any_req) begin
          owner        <= pick;
          cmd_q        <= sel_cmd;
          gnt1         <= (pick == CH1);
          gnt2         <= (pick == CH2);
          snd.snd_ch1  <= (pick == CH1);
          snd.snd_ch2  <= (pick == CH2);
          snd.snd_up   <= sel_cmd[CMD_UP];
          snd.snd_down <= sel_cmd[CMD_DOWN];
          busy         <= 1'b1;
          state        <= SETUP;
        end
        SETUP: if (!fin) begin
          snd.snd_go <= 1'b1;
          go_cnt     <= GO_LAST;
          state      <= GO;
        end
        GO: begin
          if (go_cnt == 4'd0) begin
            snd.snd_go <= 1'b0;
            tmo_cnt    <= '0;
            state      <= WAIT;
          end else begin
            go_cnt <= go_cnt - 1'b1;
          end
        end
        WAIT: if (!fin) tmo_cnt <= tmo_cnt + 1'b1;
        DONE: begin
          done1   <= 1'b0;
          done2   <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
          tmo_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (fin) begin
        done1        <= (owner == CH1);
        done2        <= (owner == CH2);
        err          <= fin_err;
        gnt1         <= 1'b0;
        gnt2         <= 1'b0;
        snd.snd_ch1  <= 1'b0;
        snd.snd_ch2  <= 1'b0;
        snd.snd_up   <= 1'b0;
        snd.snd_down <= 1'b0;
        tmo_cnt      <= '0;
        state        <= DONE;
      end
    end
  end

`ifdef SENDER_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt1   <= '0;
      cnt2   <= '0;
      errcnt <= '0;
    end else begin
      if (done1 && !err) cnt1 <= cnt1 + 1'b1;
      if (done2 && !err) cnt2 <= cnt2 + 1'b1;
      if ((done1 || done2) && err && errcnt != 8'hFF) errcnt <= errcnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sender_arbiter.sv
// Directed scoreboard bench for sender_arbiter: dut_a (GO_LEN=1) and dut_b (GO_LEN=4), both TIMEOUT=20.
module tb_sender_arbiter;
  import sender_arb_pkg::*;

  typedef struct packed {
    logic ch;
    logic err;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  logic req1_a, req2_a, req1_b, req2_b;
  logic [1:0] cmd1_a, cmd2_a, cmd1_b, cmd2_b;
  logic gnt1_a, gnt2_a, done1_a, done2_a, err_a, busy_a;
  logic gnt1_b, gnt2_b, done1_b, done2_b, err_b, busy_b;
`ifdef SENDER_ARB_STATS_EN
  logic [15:0] cnt1_a, cnt2_a, cnt1_b, cnt2_b;
  logic [7:0]  errcnt_a, errcnt_b;
`endif

  sender_arbiter_if snd_a ();
  sender_arbiter_if snd_b ();

  int vectors = 0;
  int miscompares = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  sender_arbiter #(.GO_LEN(1), .TIMEOUT(20), .CW(16)) dut_a (
    .clk(clk), .reset(rst_a), .req1(req1_a), .req2(req2_a), .cmd1(cmd1_a), .cmd2(cmd2_a),
    .gnt1(gnt1_a), .gnt2(gnt2_a), .done1(done1_a), .done2(done2_a), .err(err_a), .busy(busy_a),
`ifdef SENDER_ARB_STATS_EN
    .cnt1(cnt1_a), .cnt2(cnt2_a), .errcnt(errcnt_a),
`endif
    .snd(snd_a)
  );

  sender_arbiter #(.GO_LEN(4), .TIMEOUT(20), .CW(16)) dut_b (
    .clk(clk), .reset(rst_b), .req1(req1_b), .req2(req2_b), .cmd1(cmd1_b), .cmd2(cmd2_b),
    .gnt1(gnt1_b), .gnt2(gnt2_b), .done1(done1_b), .done2(done2_b), .err(err_b), .busy(busy_b),
`ifdef SENDER_ARB_STATS_EN
    .cnt1(cnt1_b), .cnt2(cnt2_b), .errcnt(errcnt_b),
`endif
    .snd(snd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit to_b, input logic ch, input logic e);
    exp_t x;
    x.ch  = ch;
    x.err = e;
    if (to_b) q_b.push_back(x);
    else      q_a.push_back(x);
  endtask

  // Monitors: pop an expectation on every done pulse and watch link invariants.
  always @(negedge clk) begin
    exp_t e;
    if (rst_a) begin
      if (gnt1_a || gnt2_a) check("a_gnt_exclusive", gnt1_a & gnt2_a, 0);
      if (snd_a.snd_go) check("a_go_owned", gnt1_a | gnt2_a, 1);
      if (done1_a || done2_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_done", {done1_a, done2_a}, 0);
        end else begin
          e = q_a.pop_front();
          check("a_done_single", done1_a & done2_a, 0);
          check("a_done_ch", done2_a, e.ch);
          check("a_done_err", err_a, e.err);
        end
      end
    end
    if (rst_b) begin
      if (gnt1_b || gnt2_b) check("b_gnt_exclusive", gnt1_b & gnt2_b, 0);
      if (snd_b.snd_go) check("b_go_owned", gnt1_b | gnt2_b, 1);
      if (done1_b || done2_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_done", {done1_b, done2_b}, 0);
        end else begin
          e = q_b.pop_front();
          check("b_done_ch", done2_b, e.ch);
          check("b_done_err", err_b, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int go_cycles;
    int first_go;
    logic exp_ch;

    rst_a = 1'b0; rst_b = 1'b0;
    req1_a = 0; req2_a = 0; cmd1_a = 0; cmd2_a = 0;
    req1_b = 0; req2_b = 0; cmd1_b = 0; cmd2_b = 0;
    snd_a.snd_comp = 1'b0;
    snd_b.snd_comp = 1'b0;
    repeat (2) @(negedge clk);
    check("a_reset_outputs", {gnt1_a, gnt2_a, done1_a, done2_a, err_a, busy_a, snd_a.snd_ch1,
                              snd_a.snd_ch2, snd_a.snd_up, snd_a.snd_down, snd_a.snd_go}, 0);
    check("b_reset_outputs", {gnt1_b, gnt2_b, done1_b, done2_b, err_b, busy_b, snd_b.snd_ch1,
                              snd_b.snd_ch2, snd_b.snd_up, snd_b.snd_down, snd_b.snd_go}, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    // Tie held through three transfers: ch1, ch2, ch1.
    req1_a = 1; req2_a = 1; cmd1_a = 2'b01; cmd2_a = 2'b10;
    push(0, CH1, 0); push(0, CH2, 0); push(0, CH1, 0);
    for (int i = 0; i < 3; i++) begin
      exp_ch = (i == 1) ? CH2 : CH1;
      k = 0;
      while (!(gnt1_a || gnt2_a) && k < 20) begin @(negedge clk); k++; end
      check("tie_gnt2", gnt2_a, exp_ch);
      check("tie_snd_ch2", snd_a.snd_ch2, exp_ch);
      check("tie_snd_up", snd_a.snd_up, !exp_ch);
      k = 0;
      while (!snd_a.snd_go && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      snd_a.snd_comp = 1'b1;
      @(negedge clk);
      snd_a.snd_comp = 1'b0;
      check("tie_done", done1_a | done2_a, 1);
      if (i == 2) begin req1_a = 0; req2_a = 0; end
      @(negedge clk);
    end

    // Single request ch1, comp five cycles after go; cmd change after grant ignored.
    req1_a = 1; cmd1_a = 2'b01;
    push(0, CH1, 0);
    @(negedge clk);
    check("single_gnt1", {gnt1_a, gnt2_a}, 2'b10);
    check("single_ch_up", {snd_a.snd_ch1, snd_a.snd_ch2, snd_a.snd_up, snd_a.snd_down}, 4'b1010);
    check("single_setup_go", snd_a.snd_go, 0);
    check("single_busy", busy_a, 1);
    cmd1_a = 2'b10;
    @(negedge clk);
    check("single_go_n2", snd_a.snd_go, 1);
    check("single_cmd_held", {snd_a.snd_up, snd_a.snd_down}, 2'b10);
    @(negedge clk);
    check("single_go_len1", snd_a.snd_go, 0);
    repeat (4) @(negedge clk);
    check("single_no_early_done", done1_a, 0);
    snd_a.snd_comp = 1'b1;
    @(negedge clk);
    snd_a.snd_comp = 1'b0;
    check("single_done1", {done1_a, err_a}, 2'b10);
    check("single_release", {gnt1_a, snd_a.snd_ch1, snd_a.snd_up}, 0);
    req1_a = 0;
    @(negedge clk);
    check("single_after_done", {done1_a, busy_a}, 0);

    // Timeout on ch2: done 20 WAIT cycles after go falls.
    req2_a = 1; cmd2_a = 2'b10;
    push(0, CH2, 1);
    @(negedge clk);
    check("tmo_gnt2", gnt2_a, 1);
    @(negedge clk);
    check("tmo_go", snd_a.snd_go, 1);
    @(negedge clk);
    check("tmo_go_fell", snd_a.snd_go, 0);
    repeat (19) @(negedge clk);
    check("tmo_not_yet", {done2_a, busy_a}, 2'b01);
    @(negedge clk);
    check("tmo_done2_err", {done2_a, err_a}, 2'b11);
    req2_a = 0;
    @(negedge clk);
    check("tmo_busy_low", busy_a, 0);

    // Illegal command on ch1: straight to DONE with err, no go.
    req1_a = 1; cmd1_a = 2'b11;
    push(0, CH1, 1);
    @(negedge clk);
    check("ill_gnt1", gnt1_a, 1);
    check("ill_no_go_setup", snd_a.snd_go, 0);
    @(negedge clk);
    check("ill_done_err", {done1_a, err_a, snd_a.snd_go, gnt1_a}, 4'b1100);
    req1_a = 0;
    @(negedge clk);
    check("ill_idle", {busy_a, snd_a.snd_go}, 0);

    // Stale comp through IDLE/SETUP/GO ignored; req drop mid-transfer still completes.
    req2_a = 1; cmd2_a = 2'b00; snd_a.snd_comp = 1'b1;
    push(0, CH2, 0);
    @(negedge clk);
    check("stale_gnt2", gnt2_a, 1);
    @(negedge clk);
    check("stale_go_cmd00", {snd_a.snd_go, snd_a.snd_up, snd_a.snd_down, done2_a}, 4'b1000);
    @(negedge clk);
    check("stale_in_wait", {snd_a.snd_go, done2_a, busy_a}, 3'b001);
    snd_a.snd_comp = 1'b0;
    req2_a = 0;
    @(negedge clk);
    check("stale_still_wait", {gnt2_a, done2_a, busy_a}, 3'b101);
    repeat (2) @(negedge clk);
    snd_a.snd_comp = 1'b1;
    @(negedge clk);
    snd_a.snd_comp = 1'b0;
    check("stale_done2", {done2_a, err_a}, 2'b10);
    @(negedge clk);
    check("stale_idle", {busy_a, gnt2_a}, 0);

    // dut_b: GO_LEN=4 transfer on ch1, so last_grant becomes ch1.
    req1_b = 1; cmd1_b = 2'b01;
    push(1, CH1, 0);
    @(negedge clk);
    check("b_gnt1", gnt1_b, 1);
    go_cycles = 0; first_go = -1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (snd_b.snd_go) begin
        go_cycles++;
        if (first_go < 0) first_go = j;
      end
    end
    check("b_go_len4", go_cycles, 4);
    check("b_go_start", first_go, 0);
    snd_b.snd_comp = 1'b1;
    @(negedge clk);
    snd_b.snd_comp = 1'b0;
    check("b_done1", done1_b, 1);
    req1_b = 0;
    @(negedge clk);

    // Tie goes to ch2; reset in the 2nd go cycle aborts with no done.
    req1_b = 1; req2_b = 1; cmd1_b = 2'b01; cmd2_b = 2'b10;
    @(negedge clk);
    check("b_rr_gnt2", {gnt1_b, gnt2_b}, 2'b01);
    @(negedge clk);
    @(negedge clk);
    check("b_go_2nd", snd_b.snd_go, 1);
    rst_b = 1'b0;
    #1;
    check("b_async_abort", {gnt1_b, gnt2_b, done1_b, done2_b, err_b, busy_b, snd_b.snd_ch1,
                            snd_b.snd_ch2, snd_b.snd_up, snd_b.snd_down, snd_b.snd_go}, 0);
    @(negedge clk);
    check("b_no_done_in_reset", {done1_b, done2_b}, 0);
    rst_b = 1'b1;
    push(1, CH1, 0);
    @(negedge clk);
    check("b_post_reset_gnt1", {gnt1_b, gnt2_b}, 2'b10);
    k = 0;
    while (!snd_b.snd_go && k < 20) begin @(negedge clk); k++; end
    k = 0;
    while (snd_b.snd_go && k < 20) begin @(negedge clk); k++; end
    snd_b.snd_comp = 1'b1;
    @(negedge clk);
    snd_b.snd_comp = 1'b0;
    check("b_post_reset_done1", done1_b, 1);
    req1_b = 0; req2_b = 0;
    repeat (3) @(negedge clk);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
`ifdef SENDER_ARB_STATS_EN
    check("stats_cnt1", cnt1_a, 3);
    check("stats_cnt2", cnt2_a, 2);
    check("stats_errcnt", errcnt_a, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
